pwm_duty_gen: RTL and testbench

- Programmable duty-cycle generator. Replaces the fixed 40 % duty block with a run-time programmable period and high time.
- New period/duty values go through a shadow register and take effect only at a period boundary, so the output never shows a glitched period.
- Supports continuous and one-shot modes.
- Feeds timing strobes and PWM drive in the same clock domain.

---
 rtl/pwm_duty_gen_if.sv | 25 ++
 rtl/pwm_duty_gen.sv | 110 +++++++++++
 tb/tb_pwm_duty_gen.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/pwm_duty_gen_if.sv
// Control/status bundle for pwm_duty_gen: run controls and shadow-load inputs,
// plus the registered PWM and timing outputs.
interface pwm_duty_gen_if #(
    parameter int CNT_W = 8
);
    logic             en;
    logic             oneshot;
    logic             load;
    logic [CNT_W-1:0] period_in;
    logic [CNT_W-1:0] duty_in;
    logic             pwm_out;
    logic [CNT_W-1:0] count;
    logic             period_done;
    logic             pending;

    modport master (
        output en, oneshot, load, period_in, duty_in,
        input  pwm_out, count, period_done, pending
    );

    modport slave (
        input  en, oneshot, load, period_in, duty_in,
        output pwm_out, count, period_done, pending
    );
endinterface

// File: rtl/pwm_duty_gen.sv
// Programmable PWM generator: shadowed period/duty applied at period boundaries,
// continuous or one-shot operation, all outputs registered.
module pwm_duty_gen #(
    parameter int CNT_W      = 8,
    parameter int DEF_PERIOD = 10,
    parameter int DEF_DUTY   = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    pwm_duty_gen_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e           state_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] act_p_q, act_d_q;
    logic [CNT_W-1:0] sh_p_q, sh_d_q;
    logic             pwm_q, done_q, pend_q;

    logic [CNT_W-1:0] act_p_d, act_d_d;
    logic [CNT_W-1:0] last_cnt, cnt_inc;
    logic             wrap;

    // A period of 0 is treated as 1, so its last position is also 0.
    assign last_cnt = (act_p_q == '0) ? '0 : act_p_q - 1'b1;
    assign cnt_inc  = count_q + 1'b1;
    assign wrap     = (state_q == RUN) && bus.en && (count_q == last_cnt);

    // Values governing the next period; a load coinciding with a wrap wins over the older shadow.
    always_comb begin
        act_p_d = act_p_q;
        act_d_d = act_d_q;
        if (state_q == RUN) begin
            if (wrap && bus.load) begin
                act_p_d = bus.period_in;
                act_d_d = bus.duty_in;
            end else if (wrap && pend_q) begin
                act_p_d = sh_p_q;
                act_d_d = sh_d_q;
            end
        end else if (pend_q) begin
            act_p_d = sh_p_q;
            act_d_d = sh_d_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            act_p_q <= CNT_W'(DEF_PERIOD);
            act_d_q <= CNT_W'(DEF_DUTY);
            sh_p_q  <= '0;
            sh_d_q  <= '0;
            pwm_q   <= 1'b0;
            done_q  <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            act_p_q <= act_p_d;
            act_d_q <= act_d_d;
            if (bus.load) begin
                sh_p_q <= bus.period_in;
                sh_d_q <= bus.duty_in;
            end
            unique case (state_q)
                IDLE: begin
                    pend_q <= bus.load;
                    if (bus.en) begin
                        state_q <= RUN;
                        count_q <= '0;
                        pwm_q   <= (act_d_d != '0);
                    end
                end
                RUN: begin
                    if (!bus.en) begin
                        state_q <= IDLE;
                        count_q <= '0;
                        pwm_q   <= 1'b0;
                        if (bus.load) pend_q <= 1'b1;
                    end else if (wrap) begin
                        done_q  <= 1'b1;
                        pend_q  <= 1'b0;
                        count_q <= '0;
                        if (bus.oneshot) begin
                            state_q <= DONE;
                            pwm_q   <= 1'b0;
                        end else begin
                            pwm_q   <= (act_d_d != '0);
                        end
                    end else begin
                        count_q <= cnt_inc;
                        pwm_q   <= (cnt_inc < act_d_q);
                        if (bus.load) pend_q <= 1'b1;
                    end
                end
                DONE: begin
                    pend_q <= bus.load;
                    if (!bus.en) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.pwm_out     = pwm_q;
    assign bus.count       = count_q;
    assign bus.period_done = done_q;
    assign bus.pending     = pend_q;
endmodule

// File: tb/tb_pwm_duty_gen.sv
// Randomized bench for pwm_duty_gen against an integer reference model,
// with a directed opening that pins known waveform positions.
module tb_pwm_duty_gen;
    localparam int W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   passes = 0;

    pwm_duty_gen_if #(.CNT_W(W)) bus ();

    pwm_duty_gen #(.CNT_W(W), .DEF_PERIOD(10), .DEF_DUTY(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: position in period, active and shadow settings as plain ints.
    int m_ap = 10, m_ad = 4, m_sp = 0, m_sd = 0, m_pos = 0;
    bit m_pend = 0, m_run = 0, m_spent = 0, m_pwm = 0, m_done = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ap = 10; m_ad = 4; m_sp = 0; m_sd = 0; m_pos = 0;
            m_pend = 0; m_run = 0; m_spent = 0; m_pwm = 0; m_done = 0;
        end else begin
            int ep;
            ep = (m_ap == 0) ? 1 : m_ap;
            m_done = 0;
            if (m_run) begin
                if (!bus.en) begin
                    m_run = 0; m_pos = 0; m_pwm = 0;
                    if (bus.load) begin
                        m_sp = int'(bus.period_in); m_sd = int'(bus.duty_in); m_pend = 1;
                    end
                end else if (m_pos == ep - 1) begin
                    m_done = 1;
                    if (bus.load) begin
                        m_sp = int'(bus.period_in); m_sd = int'(bus.duty_in);
                        m_ap = m_sp; m_ad = m_sd;
                    end else if (m_pend) begin
                        m_ap = m_sp; m_ad = m_sd;
                    end
                    m_pend = 0;
                    m_pos  = 0;
                    if (bus.oneshot) begin
                        m_run = 0; m_spent = 1; m_pwm = 0;
                    end else begin
                        m_pwm = (m_ad > 0);
                    end
                end else begin
                    m_pos = m_pos + 1;
                    m_pwm = (m_pos < m_ad);
                    if (bus.load) begin
                        m_sp = int'(bus.period_in); m_sd = int'(bus.duty_in); m_pend = 1;
                    end
                end
            end else begin
                if (m_pend) begin
                    m_ap = m_sp; m_ad = m_sd; m_pend = 0;
                end
                if (bus.load) begin
                    m_sp = int'(bus.period_in); m_sd = int'(bus.duty_in); m_pend = 1;
                end
                if (m_spent) begin
                    if (!bus.en) m_spent = 0;
                end else if (bus.en) begin
                    m_run = 1; m_pos = 0; m_pwm = (m_ad > 0);
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    endtask

    always @(negedge clk) begin
        chk("model.count",   int'(bus.count),       m_pos);
        chk("model.pwm",     int'(bus.pwm_out),     int'(m_pwm));
        chk("model.done",    int'(bus.period_done), int'(m_done));
        chk("model.pending", int'(bus.pending),     int'(m_pend));
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        bus.en = 1'b0; bus.oneshot = 1'b0; bus.load = 1'b0;
        bus.period_in = '0; bus.duty_in = '0;

        tick(2);
        chk("rst.count", int'(bus.count), 0);
        chk("rst.pwm", int'(bus.pwm_out), 0);
        chk("rst.pending", int'(bus.pending), 0);
        rst_n  = 1'b1;
        bus.en = 1'b1;

        // Defaults: 4 high / 6 low, period_done on the 9 -> 0 wrap.
        tick();
        chk("def.first_count", int'(bus.count), 0);
        chk("def.first_pwm", int'(bus.pwm_out), 1);
        tick(4);
        chk("def.c4_count", int'(bus.count), 4);
        chk("def.c4_pwm", int'(bus.pwm_out), 0);
        tick(5);
        chk("def.c9_count", int'(bus.count), 9);
        chk("def.c9_done", int'(bus.period_done), 0);
        tick();
        chk("def.wrap_count", int'(bus.count), 0);
        chk("def.wrap_done", int'(bus.period_done), 1);
        chk("def.wrap_pwm", int'(bus.pwm_out), 1);

        // Mid-period reload at count 3 to period 5 / duty 2.
        tick(3);
        chk("upd.at3", int'(bus.count), 3);
        bus.load = 1'b1; bus.period_in = 8'd5; bus.duty_in = 8'd2;
        tick();
        bus.load = 1'b0;
        chk("upd.pending", int'(bus.pending), 1);
        tick(5);
        chk("upd.c9_count", int'(bus.count), 9);
        chk("upd.c9_pending", int'(bus.pending), 1);
        tick();
        chk("upd.wrap_pending", int'(bus.pending), 0);
        chk("upd.wrap_done", int'(bus.period_done), 1);
        tick(2);
        chk("upd.c2_pwm", int'(bus.pwm_out), 0);
        tick(3);
        chk("upd.p5_done", int'(bus.period_done), 1);
        chk("upd.p5_count", int'(bus.count), 0);

        // Abort at count 2.
        tick(2);
        chk("abort.at2", int'(bus.count), 2);
        bus.en = 1'b0;
        tick();
        chk("abort.count", int'(bus.count), 0);
        chk("abort.pwm", int'(bus.pwm_out), 0);
        chk("abort.done", int'(bus.period_done), 0);

        // Async reset with a load outstanding.
        bus.en = 1'b1;
        tick();
        bus.load = 1'b1; bus.period_in = 8'd7; bus.duty_in = 8'd3;
        tick();
        bus.load = 1'b0;
        chk("areset.pend_before", int'(bus.pending), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("areset.count", int'(bus.count), 0);
        chk("areset.pwm", int'(bus.pwm_out), 0);
        chk("areset.pending", int'(bus.pending), 0);
        tick();
        rst_n = 1'b1;
        tick(12);

        // Period 0 behaves as 1: done every cycle, count stuck at 0.
        bus.load = 1'b1; bus.period_in = 8'd0; bus.duty_in = 8'd1;
        tick();
        bus.load = 1'b0;
        tick(12);
        chk("p0.count", int'(bus.count), 0);
        chk("p0.done", int'(bus.period_done), 1);

        repeat (3000) begin
            @(posedge clk);
            #2;
            if ($urandom_range(0, 99) < 4) bus.en = ~bus.en;
            if ($urandom_range(0, 99) < 2) bus.oneshot = ~bus.oneshot;
            bus.load      = ($urandom_range(0, 99) < 6);
            bus.period_in = W'($urandom_range(0, 12));
            bus.duty_in   = W'($urandom_range(0, 14));
            if ($urandom_range(0, 999) < 3) begin
                #1 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
        end
        bus.load = 1'b0;
        tick(2);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
